// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg
//   Shared constants and helpers for the FIFO read-side stream adapter.
//   WordLengthDef : default data width (must match the upstream FIFO)
//   RdBufDepth    : number of prefetch buffer entries
//   word_t        : default-width data word type
//   ptr_next()    : advance a buffer pointer with 2 -> 0 wrap
package fifo_rd_stream_pkg;

  localparam int WordLengthDef = 8;
  localparam int RdBufDepth    = 3;

  typedef logic [WordLengthDef-1:0] word_t;
  typedef logic [1:0]               ptr_t;

  localparam ptr_t PtrLast = 2'd2;

  // The buffer has three slots, so a 2-bit pointer skips the code 3.
  function automatic ptr_t ptr_next(input ptr_t p);
    ptr_t n;
    if (p == PtrLast) begin
      n = 2'd0;
    end else begin
      n = p + 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if
//   Bundles the FIFO read port and the outgoing valid/ready stream.
//   FIFO side  : empty_i (FIFO empty), rd_o (pop strobe), r_data_i (read data)
//   Stream side: m_data_o, m_valid_o, m_last_o (to consumer), m_ready_i (from consumer)
//   slave  modport: the adapter's view
//   master modport: the environment's view (FIFO + consumer)
interface fifo_rd_stream_if
  import fifo_rd_stream_pkg::*;
#(
  parameter int WordLength = WordLengthDef
) ();

  logic                  empty_i;
  logic                  rd_o;
  logic [WordLength-1:0] r_data_i;
  logic [WordLength-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic                  m_last_o;

  modport slave (
    input  empty_i,
    input  r_data_i,
    input  m_ready_i,
    output rd_o,
    output m_data_o,
    output m_valid_o,
    output m_last_o
  );

  modport master (
    output empty_i,
    output r_data_i,
    output m_ready_i,
    input  rd_o,
    input  m_data_o,
    input  m_valid_o,
    input  m_last_o
  );

endinterface

// File: rtl/fifo_rd_stream_buf.sv
// fifo_rd_stream_buf
//   Three-entry circular prefetch buffer with its own occupancy count.
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-low reset
//   i_push      : write i_push_data into the next free slot
//   i_push_data : word to store
//   i_pop       : drop the oldest word (caller only pops when o_count != 0)
//   o_data      : oldest stored word (slot at the read pointer)
//   o_count     : number of stored words, 0..3
module fifo_rd_stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int WordLength = WordLengthDef
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_push,
  input  logic [WordLength-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [WordLength-1:0] o_data,
  output logic [1:0]            o_count
);

  logic [WordLength-1:0] r_mem [RdBufDepth];
  ptr_t                  r_wr_ptr;
  ptr_t                  r_rd_ptr;
  logic [1:0]            r_occ;
  logic [WordLength-1:0] w_rd_word;

  // Storage: the slot addressed by the write pointer takes the pushed word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < RdBufDepth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RdBufDepth; i++) begin
        if (i_push && (r_wr_ptr == ptr_t'(i))) begin
          r_mem[i] <= i_push_data;
        end
      end
    end
  end

  // Pointer update: each advances independently on push / pop.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
    end
  end

  // Occupancy: a push and a pop in the same cycle cancel out.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_occ <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Read mux: pointer code 3 is unreachable and reads as zero.
  always_comb begin
    w_rd_word = '0;
    case (r_rd_ptr)
      2'd0:    w_rd_word = r_mem[0];
      2'd1:    w_rd_word = r_mem[1];
      2'd2:    w_rd_word = r_mem[2];
      default: w_rd_word = '0;
    endcase
  end

  assign o_data  = w_rd_word;
  assign o_count = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side adapter for the FIFO: pops words through rd/empty and presents
//   them as a valid/ready stream at one word per cycle. The FIFO's one-cycle
//   read latency is hidden by a 3-entry prefetch buffer, and every PktLen-th
//   delivered word is flagged with m_last_o.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset (shared with the FIFO)
//   bus   : FIFO read port + outgoing stream (fifo_rd_stream_if.slave)
//   Parameters: WordLength (data width), PktLen (words per packet, 1..256)
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WordLength = WordLengthDef,
  parameter int PktLen     = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  fifo_rd_stream_if.slave bus
);

  // A one-word packet still needs a 1-bit counter to keep widths legal.
  localparam int              CntW     = (PktLen > 1) ? $clog2(PktLen) : 1;
  localparam logic [CntW-1:0] BeatLast = CntW'(PktLen - 1);
  localparam logic [CntW-1:0] BeatOne  = CntW'(1);

  logic                  r_inflight;
  logic [CntW-1:0]       r_beat_cnt;
  logic [1:0]            w_occ;
  logic [2:0]            w_credit;
  logic                  w_rd;
  logic                  w_valid;
  logic                  w_handshake;
  logic                  w_last;
  logic [WordLength-1:0] w_data;

  // Words already buffered plus the one on its way from the FIFO; a new pop
  // is only issued while that total leaves a free slot, so the buffer can
  // never overflow. The consumer's ready is deliberately not in this path.
  assign w_credit    = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_rd        = rst_i & ~bus.empty_i & (w_credit < 3'd3);

  assign w_valid     = (w_occ != 2'd0);
  assign w_handshake = w_valid & bus.m_ready_i;
  assign w_last      = w_valid & (r_beat_cnt == BeatLast);

  // In-flight flag: a pop at this edge returns its word during the next cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
    end
  end

  // Beat counter: only handshakes advance it, so a FIFO underrun mid-packet
  // simply pauses the packet.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_beat_cnt <= '0;
    end else if (w_handshake) begin
      if (r_beat_cnt == BeatLast) begin
        r_beat_cnt <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + BeatOne;
      end
    end
  end

  // The returning FIFO word is captured exactly one cycle after its pop.
  fifo_rd_stream_buf #(
    .WordLength (WordLength)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_push      (r_inflight),
    .i_push_data (bus.r_data_i),
    .i_pop       (w_handshake),
    .o_data      (w_data),
    .o_count     (w_occ)
  );

  assign bus.rd_o      = w_rd;
  assign bus.m_valid_o = w_valid;
  assign bus.m_data_o  = w_data;
  assign bus.m_last_o  = w_last;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
//   Randomised and directed bench for fifo_rd_stream. The FIFO is modelled as
//   a queue; the expected stream is simply every word written, in order, with
//   a last flag on every PL-th delivered word.
module tb_fifo_rd_stream;
  import fifo_rd_stream_pkg::*;

  localparam int W  = WordLengthDef;
  localparam int PL = 4;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  fifo_rd_stream_if #(.WordLength(W)) dif ();

  fifo_rd_stream #(
    .WordLength (W),
    .PktLen     (PL)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (dif)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] fifo_q [$];   // words still inside the modelled FIFO
  logic [W-1:0] sb     [$];   // words written but not yet delivered
  logic [W:0]   hs_log [$];   // {last, data} of each delivered word

  // model state: buffered words, pop-in-flight, position in packet
  int occ_m   = 0;
  int inf_m   = 0;
  int beat_m  = 0;
  int cyc     = 0;
  int rd_cnt  = 0;
  int rd_cyc  = -1;
  int val_cyc = -1;
  int last_cnt = 0;
  bit e_valid, e_rd, e_hs;
  logic rd_now;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Per-cycle compare against the behavioural model, sampled mid-cycle.
  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      check("rst_rd_o", dif.rd_o, 0);
      check("rst_m_valid_o", dif.m_valid_o, 0);
      check("rst_m_last_o", dif.m_last_o, 0);
      check("rst_m_data_o", dif.m_data_o, 0);
      occ_m  = 0;
      inf_m  = 0;
      beat_m = 0;
    end else begin
      e_valid = (occ_m != 0);
      e_rd    = !dif.empty_i && ((occ_m + inf_m) < 3);
      check("rd_o", dif.rd_o, e_rd);
      check("m_valid_o", dif.m_valid_o, e_valid);
      check("m_last_o", dif.m_last_o, e_valid && (beat_m == PL - 1));
      if (e_valid) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) check("m_data_o", dif.m_data_o, sb[0]);
      end
      if (dif.rd_o) begin
        rd_cnt++;
        if (rd_cyc < 0) rd_cyc = cyc;
      end
      if (dif.m_valid_o && val_cyc < 0) val_cyc = cyc;
      e_hs = e_valid && dif.m_ready_i;
      if (e_hs) begin
        hs_log.push_back({dif.m_last_o, dif.m_data_o});
        if (dif.m_last_o) last_cnt++;
        if (sb.size() > 0) void'(sb.pop_front());
        beat_m = (beat_m + 1) % PL;
      end
      occ_m = occ_m + inf_m - (e_hs ? 1 : 0);
      inf_m = e_rd ? 1 : 0;
    end
  end

  task automatic fifo_write(input logic [W-1:0] w);
    fifo_q.push_back(w);
    sb.push_back(w);
    dif.empty_i = 1'b0;
  endtask

  // One clock: note the pop request, then act as the FIFO after the edge.
  task automatic step(input logic rdy);
    @(negedge clk_i);
    rd_now = dif.rd_o;
    @(posedge clk_i);
    #1;
    if (rd_now && fifo_q.size() > 0) dif.r_data_i = fifo_q.pop_front();
    else dif.r_data_i = W'($urandom);
    dif.m_ready_i = rdy;
    dif.empty_i   = (fifo_q.size() == 0);
  endtask

  task automatic run(input logic rdy, input int n);
    repeat (n) step(rdy);
  endtask

  task automatic clear_logs();
    hs_log.delete();
    rd_cnt   = 0;
    rd_cyc   = -1;
    val_cyc  = -1;
    last_cnt = 0;
  endtask

  task automatic check_seq(input string name, input int n, input logic [W-1:0] base,
                           input int last_a, input int last_b);
    check({name, "_count"}, hs_log.size(), n);
    for (int i = 0; i < n && i < hs_log.size(); i++) begin
      check({name, "_data"}, hs_log[i][W-1:0], base + W'(i));
      check({name, "_last"}, hs_log[i][W], (i == last_a) || (i == last_b));
    end
  endtask

  initial begin
    int wr_total;
    int budget;
    int nw;
    logic rdy;

    // reset held with a non-empty FIFO
    rst_i         = 1'b0;
    dif.empty_i   = 1'b0;
    dif.m_ready_i = 1'b1;
    dif.r_data_i  = 8'h5A;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_rd_o", dif.rd_o, 0);
    check("reset_m_valid_o", dif.m_valid_o, 0);
    check("reset_m_last_o", dif.m_last_o, 0);
    check("reset_m_data_o", dif.m_data_o, 0);
    dif.empty_i = 1'b1;
    #1 rst_i = 1'b1;
    run(1'b1, 3);

    // streaming 0x01..0x08 with ready high
    clear_logs();
    for (int i = 1; i <= 8; i++) fifo_write(W'(i));
    run(1'b1, 14);
    check_seq("stream", 8, 8'h01, 3, 7);
    check("first_valid_latency", val_cyc - rd_cyc, 2);

    // backpressure: three pops then stall, head word held
    clear_logs();
    for (int i = 1; i <= 8; i++) fifo_write(W'(i));
    run(1'b0, 10);
    check("bp_rd_pulses", rd_cnt, 3);
    check("bp_valid", dif.m_valid_o, 1);
    check("bp_data_held", dif.m_data_o, 8'h01);
    check("bp_no_handshake", hs_log.size(), 0);
    run(1'b1, 16);
    check_seq("bp_release", 8, 8'h01, 3, 7);

    // underflow mid-packet, then refill
    clear_logs();
    fifo_write(8'h10);
    fifo_write(8'h11);
    run(1'b1, 8);
    check("uf_partial", hs_log.size(), 2);
    check("uf_no_last", last_cnt, 0);
    fifo_write(8'hA0);
    fifo_write(8'hA1);
    run(1'b1, 8);
    check("uf_count", hs_log.size(), 4);
    if (hs_log.size() == 4) begin
      check("uf_a0", hs_log[2], 9'h0A0);
      check("uf_a1", hs_log[3], 9'h1A1);
    end

    // random ready and FIFO writes over 1000 words
    clear_logs();
    wr_total = 0;
    budget   = 0;
    while ((wr_total < 1000 || sb.size() > 0) && budget < 20000) begin
      if (((budget / 200) % 2) == 1) rdy = 1'($urandom_range(0, 1));
      else rdy = ($urandom_range(0, 3) != 0);
      step(rdy);
      nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++) begin
        if (wr_total < 1000) begin
          fifo_write(W'($urandom));
          wr_total++;
        end
      end
      budget++;
    end
    check("rand_budget", budget < 20000, 1);
    check("rand_words", hs_log.size(), 1000);
    check("rand_lasts", last_cnt, 250);

    // mid-stream reset with occ=2 and a word in flight, mid-packet
    fifo_write(8'h55);
    run(1'b1, 5);
    clear_logs();
    for (int i = 1; i <= 8; i++) fifo_write(8'h20 + W'(i));
    run(1'b0, 3);
    check("mr_pre_valid", dif.m_valid_o, 1);
    check("mr_pre_data", dif.m_data_o, 8'h21);
    #1;
    rst_i = 1'b0;
    fifo_q.delete();
    sb.delete();
    dif.empty_i = 1'b1;
    #1;
    check("mr_rd_o", dif.rd_o, 0);
    check("mr_m_valid_o", dif.m_valid_o, 0);
    check("mr_m_last_o", dif.m_last_o, 0);
    check("mr_m_data_o", dif.m_data_o, 0);
    run(1'b0, 2);
    rst_i = 1'b1;
    run(1'b1, 2);
    clear_logs();
    for (int i = 0; i < 4; i++) fifo_write(8'h30 + W'(i));
    run(1'b1, 10);
    check_seq("mr_after", 4, 8'h30, 3, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter placed directly downstream of the `fifo` block. It pulls words out of the FIFO through its `rd`/`empty` interface and presents them as a valid/ready stream, sustaining one word per cycle. It hides the FIFO's one-cycle read latency behind a 3-entry prefetch buffer and marks every `PktLen`-th delivered word with `m_last_o`.

## Interface
- `WordLength`, default 8: data width; must match the FIFO.
- `PktLen`, default 4: words per packet; legal range 1..256.
- `clk_i`  in  1: single clock; all logic on the rising edge.
- `rst_i`  in  1: asynchronous, active-low reset; deassertion synchronous to `clk_i` upstream.
- `empty_i`  in  1: FIFO `empty_o`.
- `rd_o`  out  1: FIFO `rd_i`; one word popped per cycle high.
- `r_data_i`  in  WordLength: FIFO `r_data_o`; valid the cycle after `rd_o` was high.
- `m_data_o`  out  WordLength: stream data.
- `m_valid_o`  out  1: stream valid.
- `m_ready_i`  in  1: stream ready from the consumer.
- `m_last_o`  out  1: high with the last word of each packet.

## Operation
- FIFO contract: `rd_o` high at edge N pops the word; `r_data_i` carries it during cycle N+1 and is captured at edge N+1.
- State:
  - `occ`, 0..3: buffered words.
  - `inflight`, 1 bit: `rd_o` was high last cycle.
  - `beat_cnt`, 0..PktLen-1.
  - 3-entry circular buffer with 2-bit `wr_ptr`/`rd_ptr` that wrap 2 -> 0.
- Issue rule: `rd_o = rst_i && !empty_i && (occ + inflight) < 3`. It is combinational from registered state and `empty_i` only; there is no path from `m_ready_i`.
- `rd_o` never asserts while `empty_i` is high.
- Capture: when `inflight` is high, `r_data_i` is written at `wr_ptr` and `wr_ptr` advances.
- Output: `m_valid_o = (occ != 0)` and `m_data_o = buf[rd_ptr]`.
- A handshake is `m_valid_o && m_ready_i`; it advances `rd_ptr`.
- `occ` next value is `occ + inflight - handshake`. A capture and a handshake in the same cycle leave `occ` unchanged.
- Credit rule: `occ + inflight <= 3` always, so the buffer never overflows.
- Stream rule: while `m_valid_o && !m_ready_i`, `m_data_o` and `m_last_o` are held stable.
- Packet counter:
  - `m_last_o = m_valid_o && (beat_cnt == PktLen-1)`.
  - On each handshake, `beat_cnt` increments and wraps to 0 after PktLen-1.
  - With PktLen=1, `m_last_o` equals `m_valid_o`.
- The FIFO running empty mid-packet does not reset `beat_cnt`; the packet resumes when data returns.

## Timing
- Reset values:
  - `rd_o`=0 (forced low while `rst_i` is low).
  - `m_valid_o`=0, `m_last_o`=0, `m_data_o`=0.
  - `occ`=0, `inflight`=0, `beat_cnt`=0, pointers 0, buffer contents 0.
- Latency: `empty_i` falling before edge N gives `rd_o` high in cycle N-1..N, pop at edge N, and `m_valid_o` high in cycle N+2 (after capture at edge N+1).
- First-word latency from FIFO non-empty to `m_valid_o` is 2 cycles.
- Throughput:
  - With `m_ready_i` held high and a non-empty FIFO, one handshake per cycle, steady state `occ`=1 with `inflight`=1.
  - With `m_ready_i` low, at most 3 words are drained before `rd_o` stops: `occ` reaches 3, `inflight` 0.
- Reset mid-operation: the in-flight word and buffer contents are discarded, `beat_cnt` clears, and outputs return to reset values immediately (asynchronous). The FIFO shares the reset, so no word is duplicated.
- Simultaneous `empty_i` rise and `inflight` high: the in-flight word is still captured, and `rd_o` drops that cycle.

## Structure
- `fifo_pkg` (shared with `fifo` and the test bench): `WordLength` default constant, `RdBufDepth = 3`, and a typedef for the word type.
- Sub-module `fifo_rd_buf`: 3-entry circular buffer with pointers, `occ`, and push/pop/count ports.
- `fifo_rd_stream` keeps the issue logic, `inflight`, and `beat_cnt`.

## Test plan
- **Reset:** hold `rst_i` low with `empty_i`=0 -> `rd_o`=0, `m_valid_o`=0, `m_last_o`=0, `m_data_o`=0.
- **Streaming:** FIFO holds 0x01..0x08, `m_ready_i`=1 -> first valid 2 cycles after `rd_o`, then 8 consecutive beats 0x01..0x08 in order; `m_last_o` high on 0x04 and 0x08.
- **Backpressure:** `m_ready_i`=0 with 8 words queued -> exactly 3 `rd_o` pulses; `m_data_o`=0x01 held stable. Releasing ready delivers 0x01..0x08 with no loss or duplication.
- **Underflow:** FIFO empties after 2 words of a packet, then refills with 0xA0, 0xA1 -> `rd_o` never high while `empty_i`=1; `m_last_o` high on 0xA1.
- **Random ready:** random `m_ready_i` and FIFO writes over 1000 words -> scoreboard order matches, `occ + inflight <= 3` always, `m_last_o` every 4th beat.
- **Mid-stream reset:** assert `rst_i` low while `inflight`=1 and `occ`=2 -> outputs go to reset values immediately; after release, the next word accepted starts with `beat_cnt`=0.
